// File: rtl/rv32i_pkg.sv
// RV32I encoder constants: operation enum, major opcodes, funct fields
// and per-format word builders.
package rv32i_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] opc);
        return {imm[11:0], rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3,
                imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm,
        input logic [4:0] rd, input logic [6:0] opc);
        return {imm[31:12], rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/rv_encode.sv
// Combinational RV32I encoder: operation + fields -> instruction word.
module rv_encode
    import rv32i_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        unique case (op_i)
            OP_ADD:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i);
            OP_SUB:   word_o = enc_r(F7_ALT, rs2_i, rs1_i, F3_ADD, rd_i);
            OP_SLL:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLL, rd_i);
            OP_SLT:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLT, rd_i);
            OP_SLTU:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLTU, rd_i);
            OP_XOR:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_XOR, rd_i);
            OP_SRL:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SR, rd_i);
            OP_SRA:   word_o = enc_r(F7_ALT, rs2_i, rs1_i, F3_SR, rd_i);
            OP_OR:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_OR, rd_i);
            OP_AND:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_AND, rd_i);
            OP_ADDI:  word_o = enc_i(imm_i, rs1_i, F3_ADD, rd_i, OPC_OP_IMM);
            OP_LW:    word_o = enc_i(imm_i, rs1_i, F3_W, rd_i, OPC_LOAD);
            OP_SW:    word_o = enc_s(imm_i, rs2_i, rs1_i);
            OP_JALR:  word_o = enc_i(imm_i, rs1_i, F3_JALR, rd_i, OPC_JALR);
            OP_LUI:   word_o = enc_u(imm_i, rd_i, OPC_LUI);
            OP_AUIPC: word_o = enc_u(imm_i, rd_i, OPC_AUIPC);
            // Branch and jump targets must be halfword aligned
            OP_BEQ: begin
                word_o    = enc_b(imm_i, rs2_i, rs1_i, F3_BEQ);
                illegal_o = imm_i[0];
            end
            OP_BNE: begin
                word_o    = enc_b(imm_i, rs2_i, rs1_i, F3_BNE);
                illegal_o = imm_i[0];
            end
            OP_BLT: begin
                word_o    = enc_b(imm_i, rs2_i, rs1_i, F3_BLT);
                illegal_o = imm_i[0];
            end
            OP_BGE: begin
                word_o    = enc_b(imm_i, rs2_i, rs1_i, F3_BGE);
                illegal_o = imm_i[0];
            end
            OP_BLTU: begin
                word_o    = enc_b(imm_i, rs2_i, rs1_i, F3_BLTU);
                illegal_o = imm_i[0];
            end
            OP_BGEU: begin
                word_o    = enc_b(imm_i, rs2_i, rs1_i, F3_BGEU);
                illegal_o = imm_i[0];
            end
            OP_JAL: begin
                word_o    = enc_j(imm_i, rd_i);
                illegal_o = imm_i[0];
            end
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder front end: encodes requests into a 2-deep FIFO
// and streams the words into instruction memory at a running address.
module inst_encoder
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ready,
    output logic        err_illegal,
    input  logic        err_clr,
    output logic [15:0] wr_count
);

    logic [31:0] mem_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wrc_q, wrc_d;
    logic        err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        full, empty, accept, push, pop;

    rv_encode u_enc (
        .op_i      (in_op),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .imm_i     (in_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign full   = (cnt_q == 2'd2);
    assign empty  = (cnt_q == 2'd0);
    assign accept = in_valid && !full;
    assign push   = accept && !enc_illegal;
    assign pop    = !empty && imem_ready;

    assign in_ready    = !full;
    assign imem_we     = !empty;
    assign imem_wdata  = empty ? '0 : mem_q[rptr_q];
    assign imem_addr   = addr_q;
    assign err_illegal = err_q;
    assign wr_count    = wrc_q;

    always_comb begin
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        wrc_d  = wrc_q + {15'd0, pop};
        addr_d = addr_q;
        err_d  = err_q;
        if (pop)
            addr_d = addr_q + 32'd4;
        else if (base_load && empty && !push)
            addr_d = base_addr;
        if (accept && enc_illegal)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wrc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= enc_word;
                wptr_q        <= ~wptr_q;
            end
            if (pop)
                rptr_q <= ~rptr_q;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            wrc_q  <= wrc_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: clk in 1 (rising edge), rst_n in 1 (async assert, active-low).
REQ-002 SHALL have in_valid in 1: an encode request is present.
REQ-003 SHALL have in_ready out 1: a request can be accepted.
REQ-004 SHALL have in_op in 5: operation code, values defined in rv32i_pkg.
REQ-005 SHALL have in_rd, in_rs1, in_rs2 in 5 each: register indices.
REQ-006 SHALL have in_imm in 32: sign-extended immediate or offset.
REQ-007 SHALL have base_load in 1 and base_addr in 32: load the write address.
REQ-008 SHALL have imem_we out 1, imem_addr out 32, imem_wdata out 32: instruction-memory write port.
REQ-009 SHALL have imem_ready in 1: the memory accepts the write this cycle.
REQ-010 SHALL have err_illegal out 1 (sticky) and err_clr in 1 (clears it).
REQ-011 SHALL have wr_count out 16: count of words written.

Function
REQ-012 SHALL support these ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND ADDI LW SW BEQ BNE BLT BGE BLTU BGEU JAL JALR LUI AUIPC, numbered 0..22.
REQ-013 SHALL encode standard RV32I formats:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, f3, rd, opc}
- S: {imm[11:5], rs2, rs1, f3, imm[4:0], opc}
- B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}
- U: {imm[31:12], rd, opc}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}
- Unused immediate bits are ignored.
REQ-014 SHALL accept a request when in_valid && in_ready, and push the encoded word into a 2-entry FIFO in that cycle.
REQ-015 SHALL drive in_ready = !full; a push while full SHALL NOT occur, even when a pop happens in the same cycle.
REQ-016 SHALL drive imem_we = !empty, with imem_wdata = FIFO head; a word is written when imem_we && imem_ready.
REQ-017 SHALL present an accepted word on imem_wdata with imem_we=1 exactly 1 cycle after the handshake, when the FIFO was empty.
REQ-018 SHALL keep imem_addr, imem_wdata and imem_we stable while imem_we=1 and imem_ready=0.
REQ-019 SHALL increment imem_addr by 4 on each completed write, wrapping modulo 2^32.
REQ-020 SHALL increment wr_count on each completed write, wrapping at 16 bits.
REQ-021 SHALL handle an illegal request as follows:
- Illegal means in_op>22, or imm[0]=1 for branch/JAL.
- It is handshaken (in_ready honoured) but not pushed.
- It sets err_illegal on the next edge.
REQ-022 SHALL give set priority over err_clr when both occur in the same cycle.
REQ-023 SHALL honour base_load only when the FIFO is empty and no push occurs that cycle: imem_addr <= base_addr next edge; otherwise base_load is ignored.
REQ-024 SHALL preserve FIFO order on a simultaneous push and pop while not full; occupancy is unchanged.

Reset
REQ-025 SHALL, on rst_n=0, immediately (asynchronously) empty the FIFO and clear imem_we, imem_addr, imem_wdata, err_illegal and wr_count to 0.
REQ-026 SHALL drive in_ready=1 after reset release.
REQ-027 SHALL discard in-flight words when reset is asserted mid-operation; they are never written.

Structure
REQ-028 SHALL put in rv32i_pkg: the op enum, opcode constants (OP=0110011, OP_IMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111), and funct3/funct7 constants.
REQ-029 SHALL instantiate one combinational sub-module rv_encode (op, regs, imm -> word, illegal); the FIFO and address logic stay in inst_encoder.

Verification
REQ-030 SHALL cover: ADD rd=3, rs1=1, rs2=2, base 0 -> imem_wdata 0x002081B3 at addr 0x0 one cycle later.
REQ-031 SHALL cover: SUB 5,6,7 then ADDI 1,0,imm=-1 back-to-back -> 0x407302B3 @0x0, then 0xFFF00093 @0x4; wr_count=2.
REQ-032 SHALL cover: BEQ rs1=1, rs2=2, imm=8 -> 0x00208463; JAL rd=1, imm=16 -> 0x010000EF.
REQ-033 SHALL cover: imem_ready=0 with 3 requests offered -> 2 accepted, in_ready=0, outputs stable; imem_ready=1 -> drains in order, third is accepted.
REQ-034 SHALL cover: BEQ with imm=3, then in_op=25 -> nothing written, err_illegal=1 until err_clr.
REQ-035 SHALL cover: base_load with base_addr 0xFFFFFFFC, then 2 writes -> addresses 0xFFFFFFFC, 0x00000000; rst_n pulse with 2 entries queued -> imem_we=0 immediately, addr=0.
